// File: rtl/mux_rr_arbiter_if.sv
// Bundle between the four requesters, the arbiter and the downstream consumer of f.
// The arbiter sits on the slave side; requesters and downstream drive the master side.
interface mux_rr_arbiter_if #(
  parameter int DATA_W = 8
);
  logic [3:0]          req_valid;
  logic [4*DATA_W-1:0] req_data;
  logic [3:0]          req_last;
  logic [3:0]          req_ready;
  logic [1:0]          sel;
  logic [3:0]          gnt;
  logic                f_valid;
  logic [DATA_W-1:0]   f_data;
  logic                f_last;
  logic                f_ready;
  logic                preempt;

  modport master (
    output req_valid, req_data, req_last, f_ready,
    input  req_ready, sel, gnt, f_valid, f_data, f_last, preempt
  );

  modport slave (
    input  req_valid, req_data, req_last, f_ready,
    output req_ready, sel, gnt, f_valid, f_data, f_last, preempt
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for the shared 4:1 mux: grants one requester per packet (capped at
// MAX_BURST beats) and forwards its stream combinationally to f.
module mux_rr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  mux_rr_arbiter_if.slave bus
);
  localparam int NUM_LANES = 4;
  localparam int CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(MAX_BURST - 1);

  logic [0:0]           state_q, state_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [1:0]           sel_q, sel_d;
  logic [NUM_LANES-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 preempt_q, preempt_d;

  logic [NUM_LANES-1:0][DATA_W-1:0] lane_data;
  logic [NUM_LANES-1:0]             lane_rdy;
  logic                             granted, accept, cur_last;
  logic                             win_vld;
  logic [1:0]                       win_idx, idx;

  assign granted  = (state_q == ST_GRANT);
  assign cur_last = bus.req_last[sel_q];
  assign accept   = granted & bus.req_valid[sel_q] & bus.f_ready;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_data[i] = bus.req_data[i*DATA_W +: DATA_W];
    assign lane_rdy[i]  = granted & (sel_q == 2'(i)) & bus.f_ready;
  end

  // Walk downward so the candidate closest to ptr (smallest offset) is the last writer.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    idx     = ptr_q;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (bus.req_valid[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (win_vld) begin
        state_d = ST_GRANT;
        sel_d   = win_idx;
        gnt_d   = NUM_LANES'(1) << win_idx;
        cnt_d   = '0;
      end
    end else if (accept) begin
      // last wins over the burst cap, so a packet ending exactly at the cap is not a preempt
      if (cur_last || cnt_q == CNT_CAP) begin
        state_d   = ST_IDLE;
        ptr_d     = sel_q + 2'd1;
        gnt_d     = '0;
        cnt_d     = '0;
        preempt_d = ~cur_last;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      gnt_q     <= '0;
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end

  assign bus.req_ready = lane_rdy;
  assign bus.sel       = sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.preempt   = preempt_q;
  assign bus.f_valid   = granted & bus.req_valid[sel_q];
  assign bus.f_last    = granted & cur_last;
  assign bus.f_data    = granted ? lane_data[sel_q] : '0;
endmodule
